// File: rtl/falco_pkg.sv
// rtl/falco_pkg.sv - shared dispatch widths, depths and tag types
package falco_pkg;
  localparam int ROB_DEPTH     = 32;
  localparam int LSQ_DEPTH     = 16;
  localparam int ROB_TAG_WIDTH = 5;
  localparam int LFST_WIDTH    = 4;
  localparam int LFST_ENTRIES  = 1 << LFST_WIDTH;

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
  typedef logic [LFST_WIDTH-1:0]    ssid_t;
endpackage

// File: rtl/last_fetched_store_table.sv
// rtl/last_fetched_store_table.sv - store set id -> last dispatched store tag
module last_fetched_store_table
  import falco_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_all,
  input  logic [LFST_WIDTH-1:0]    rd0_ssid,
  output logic                     rd0_valid,
  output logic [ROB_TAG_WIDTH-1:0] rd0_tag,
  input  logic [LFST_WIDTH-1:0]    rd1_ssid,
  output logic                     rd1_valid,
  output logic [ROB_TAG_WIDTH-1:0] rd1_tag,
  input  logic                     wr0_en,
  input  logic [LFST_WIDTH-1:0]    wr0_ssid,
  input  logic [ROB_TAG_WIDTH-1:0] wr0_tag,
  input  logic                     wr1_en,
  input  logic [LFST_WIDTH-1:0]    wr1_ssid,
  input  logic [ROB_TAG_WIDTH-1:0] wr1_tag,
  input  logic                     clr_valid,
  input  logic [ROB_TAG_WIDTH-1:0] clr_tag
);
  logic [LFST_ENTRIES-1:0] valid_q, valid_d;
  rob_tag_t                tag_q [LFST_ENTRIES];
  rob_tag_t                tag_d [LFST_ENTRIES];

  assign rd0_valid = valid_q[rd0_ssid];
  assign rd0_tag   = tag_q[rd0_ssid];
  assign rd1_valid = valid_q[rd1_ssid];
  assign rd1_tag   = tag_q[rd1_ssid];

  // Later assignments take priority: clear < slot 0 write < slot 1 write; entry 0 is never touched.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    for (int i = 1; i < LFST_ENTRIES; i++) begin
      if (clr_valid && valid_q[i] && (tag_q[i] == clr_tag)) valid_d[i] = 1'b0;
      if (wr0_en && (wr0_ssid == LFST_WIDTH'(i))) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = wr0_tag;
      end
      if (wr1_en && (wr1_ssid == LFST_WIDTH'(i))) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = wr1_tag;
      end
    end
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LFST_ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LFST_ENTRIES; i++) tag_q[i] <= tag_d[i];
    end
  end
endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - two-wide in-order dispatch with ROB/LSQ allocation and store-set deps
module dispatch_ctrl
  import falco_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     instr0_valid,
  input  logic                     instr0_is_load,
  input  logic                     instr0_is_store,
  input  logic [LFST_WIDTH-1:0]    instr0_store_set_id,
  input  logic                     instr1_valid,
  input  logic                     instr1_is_load,
  input  logic                     instr1_is_store,
  input  logic [LFST_WIDTH-1:0]    instr1_store_set_id,
  input  logic                     backend_ready,
  input  logic [1:0]               rob_commit_cnt,
  input  logic [1:0]               lsq_release_cnt,
  input  logic                     store_done_valid,
  input  logic [ROB_TAG_WIDTH-1:0] store_done_tag,
  output logic                     instr0_issue,
  output logic                     instr1_issue,
  output logic                     id_stall_req,
  output logic [ROB_TAG_WIDTH-1:0] instr0_rob_tag,
  output logic                     instr0_dep_valid,
  output logic [ROB_TAG_WIDTH-1:0] instr0_dep_tag,
  output logic [ROB_TAG_WIDTH-1:0] instr1_rob_tag,
  output logic                     instr1_dep_valid,
  output logic [ROB_TAG_WIDTH-1:0] instr1_dep_tag,
  output logic [5:0]               rob_free_cnt,
  output logic [4:0]               lsq_free_cnt
);
  rob_tag_t   tail_q, tail_d;
  logic [5:0] rob_free_q, rob_free_d;
  logic [4:0] lsq_free_q, lsq_free_d;

  logic       mem0, mem1, go;
  logic [1:0] rob_need1, lsq_need1, rob_alloc, lsq_alloc;
  logic       wr0_en, wr1_en, bypass1;
  logic       lf0_valid, lf1_valid;
  rob_tag_t   lf0_tag, lf1_tag;

  assign mem0 = instr0_is_load | instr0_is_store;
  assign mem1 = instr1_is_load | instr1_is_store;
  assign go   = !rst && backend_ready && !flush;

  always_comb begin
    instr0_issue = go && instr0_valid && (rob_free_q >= 6'd1) && (lsq_free_q >= {4'b0, mem0});
    rob_need1    = {1'b0, instr0_issue} + 2'd1;
    lsq_need1    = {1'b0, instr0_issue & mem0} + {1'b0, mem1};
    // Slot 1 may only go if slot 0 is empty or goes with it, and both must fit together.
    instr1_issue = go && instr1_valid && (!instr0_valid || instr0_issue)
                   && (rob_free_q >= {4'b0, rob_need1}) && (lsq_free_q >= {3'b0, lsq_need1});
    id_stall_req = !rst && ((instr0_valid && !instr0_issue) || (instr1_valid && !instr1_issue));
    rob_alloc    = {1'b0, instr0_issue} + {1'b0, instr1_issue};
    lsq_alloc    = {1'b0, instr0_issue & mem0} + {1'b0, instr1_issue & mem1};
  end

  assign instr0_rob_tag = tail_q;
  assign instr1_rob_tag = tail_q + {{(ROB_TAG_WIDTH-1){1'b0}}, instr0_issue};

  assign wr0_en  = instr0_issue && instr0_is_store && (instr0_store_set_id != '0);
  assign wr1_en  = instr1_issue && instr1_is_store && (instr1_store_set_id != '0);
  assign bypass1 = wr0_en && mem1 && (instr1_store_set_id == instr0_store_set_id);

  always_comb begin
    instr0_dep_valid = mem0 && (instr0_store_set_id != '0) && lf0_valid;
    instr0_dep_tag   = lf0_tag;
    instr1_dep_valid = mem1 && (instr1_store_set_id != '0) && lf1_valid;
    instr1_dep_tag   = lf1_tag;
    if (bypass1) begin
      instr1_dep_valid = 1'b1;
      instr1_dep_tag   = instr0_rob_tag;
    end
  end

  always_comb begin
    tail_d     = tail_q + {3'b0, rob_alloc};
    rob_free_d = rob_free_q - {4'b0, rob_alloc} + {4'b0, rob_commit_cnt};
    lsq_free_d = lsq_free_q - {3'b0, lsq_alloc} + {3'b0, lsq_release_cnt};
    if (flush) begin
      tail_d     = '0;
      rob_free_d = 6'(ROB_DEPTH);
      lsq_free_d = 5'(LSQ_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q     <= '0;
      rob_free_q <= 6'(ROB_DEPTH);
      lsq_free_q <= 5'(LSQ_DEPTH);
    end else begin
      tail_q     <= tail_d;
      rob_free_q <= rob_free_d;
      lsq_free_q <= lsq_free_d;
    end
  end

  assign rob_free_cnt = rob_free_q;
  assign lsq_free_cnt = lsq_free_q;

  last_fetched_store_table u_lfst (
    .clk       (clk),
    .rst       (rst),
    .clr_all   (flush),
    .rd0_ssid  (instr0_store_set_id),
    .rd0_valid (lf0_valid),
    .rd0_tag   (lf0_tag),
    .rd1_ssid  (instr1_store_set_id),
    .rd1_valid (lf1_valid),
    .rd1_tag   (lf1_tag),
    .wr0_en    (wr0_en),
    .wr0_ssid  (instr0_store_set_id),
    .wr0_tag   (instr0_rob_tag),
    .wr1_en    (wr1_en),
    .wr1_ssid  (instr1_store_set_id),
    .wr1_tag   (instr1_rob_tag),
    .clr_valid (store_done_valid),
    .clr_tag   (store_done_tag)
  );
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - directed self-checking bench for dispatch_ctrl
module tb_dispatch_ctrl;
  logic       clk, rst, flush;
  logic       v0, ld0, st0, v1, ld1, st1;
  logic [3:0] ss0, ss1;
  logic       ready;
  logic [1:0] commit, release_cnt;
  logic       sd_valid;
  logic [4:0] sd_tag;
  logic       issue0, issue1, stall;
  logic [4:0] tag0, dtag0, tag1, dtag1;
  logic       dv0, dv1;
  logic [5:0] rob_free;
  logic [4:0] lsq_free;

  int passed = 0;
  int total  = 0;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr0_valid(v0), .instr0_is_load(ld0), .instr0_is_store(st0), .instr0_store_set_id(ss0),
    .instr1_valid(v1), .instr1_is_load(ld1), .instr1_is_store(st1), .instr1_store_set_id(ss1),
    .backend_ready(ready), .rob_commit_cnt(commit), .lsq_release_cnt(release_cnt),
    .store_done_valid(sd_valid), .store_done_tag(sd_tag),
    .instr0_issue(issue0), .instr1_issue(issue1), .id_stall_req(stall),
    .instr0_rob_tag(tag0), .instr0_dep_valid(dv0), .instr0_dep_tag(dtag0),
    .instr1_rob_tag(tag1), .instr1_dep_valid(dv1), .instr1_dep_tag(dtag1),
    .rob_free_cnt(rob_free), .lsq_free_cnt(lsq_free)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst) assert (rob_free <= 6'd32 && lsq_free <= 5'd16)
      else $error("free count out of range rob=%0d lsq=%0d", rob_free, lsq_free);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_v, a_ld, a_st, input logic [3:0] a_ss,
                       input logic b_v, b_ld, b_st, input logic [3:0] b_ss);
    v0 = a_v; ld0 = a_ld; st0 = a_st; ss0 = a_ss;
    v1 = b_v; ld1 = b_ld; st1 = b_st; ss1 = b_ss;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0; ready = 1; commit = 0; release_cnt = 0; sd_valid = 0; sd_tag = 0;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic alu_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; flush = 1;
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    #1;
    total++; if (issue0 !== 1'b0) $display("FAIL rst_issue0 got=%0d exp=0", issue0); else passed++;
    total++; if (issue1 !== 1'b0) $display("FAIL rst_issue1 got=%0d exp=0", issue1); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got=%0d exp=0", stall); else passed++;
    tick();
    rst = 0; idle();
    #1;
    total++; if (rob_free !== 6'd32) $display("FAIL rst_rob_free got=%0d exp=32", rob_free); else passed++;
    total++; if (lsq_free !== 5'd16) $display("FAIL rst_lsq_free got=%0d exp=16", lsq_free); else passed++;
    total++; if (tag0 !== 5'd0) $display("FAIL rst_tail got=%0d exp=0", tag0); else passed++;
  endtask

  task automatic test_two_alu();
    reset_dut();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    #1;
    total++; if ({issue0, issue1, stall} !== 3'b110) $display("FAIL alu_issue got=%b exp=110", {issue0, issue1, stall}); else passed++;
    total++; if (tag0 !== 5'd0 || tag1 !== 5'd1) $display("FAIL alu_tags got=%0d,%0d exp=0,1", tag0, tag1); else passed++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    ready = 0;
    #1;
    total++; if (rob_free !== 6'd30) $display("FAIL alu_rob_free got=%0d exp=30", rob_free); else passed++;
    total++; if ({issue0, stall} !== 2'b01) $display("FAIL not_ready got=%b exp=01", {issue0, stall}); else passed++;
    total++; if (tag0 !== 5'd2) $display("FAIL alu_tail got=%0d exp=2", tag0); else passed++;
    idle();
  endtask

  task automatic test_rob_limit();
    reset_dut();
    alu_pairs(16);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    commit = 1;
    #1;
    total++; if (rob_free !== 6'd0) $display("FAIL rob_full got=%0d exp=0", rob_free); else passed++;
    total++; if ({issue0, issue1, stall} !== 3'b001) $display("FAIL rob_full_issue got=%b exp=001", {issue0, issue1, stall}); else passed++;
    tick();
    total++; if (rob_free !== 6'd1) $display("FAIL rob_one got=%0d exp=1", rob_free); else passed++;
    #1;
    total++; if ({issue0, issue1, stall} !== 3'b101) $display("FAIL rob_one_issue got=%b exp=101", {issue0, issue1, stall}); else passed++;
    total++; if (tag0 !== 5'd0) $display("FAIL rob_one_tag0 got=%0d exp=0", tag0); else passed++;
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    commit = 0;
    #1;
    total++; if ({issue1, stall} !== 2'b10) $display("FAIL slot1_alone got=%b exp=10", {issue1, stall}); else passed++;
    total++; if (tag1 !== 5'd1) $display("FAIL slot1_alone_tag got=%0d exp=1", tag1); else passed++;
    tick();
    idle();
    total++; if (rob_free !== 6'd0) $display("FAIL rob_after got=%0d exp=0", rob_free); else passed++;
  endtask

  task automatic test_store_set();
    reset_dut();
    alu_pairs(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 3, 0, 0, 0, 0);
    #1;
    total++; if ({issue0, tag0} !== {1'b1, 5'd7}) $display("FAIL st_issue got=%0d tag=%0d exp=1 tag=7", issue0, tag0); else passed++;
    total++; if (dv0 !== 1'b0) $display("FAIL st_dep_empty got=%0d exp=0", dv0); else passed++;
    tick();
    drive(1, 1, 0, 3, 1, 1, 0, 0);
    #1;
    total++; if ({dv0, dtag0} !== {1'b1, 5'd7}) $display("FAIL ld_dep got=%0d/%0d exp=1/7", dv0, dtag0); else passed++;
    total++; if (dv1 !== 1'b0) $display("FAIL ld_ssid0 got=%0d exp=0", dv1); else passed++;
    tick();
    idle();
    sd_valid = 1; sd_tag = 8;
    tick();
    drive(1, 1, 0, 3, 0, 0, 0, 0);
    sd_tag = 7;
    #1;
    total++; if ({dv0, dtag0} !== {1'b1, 5'd7}) $display("FAIL sd_mismatch got=%0d/%0d exp=1/7", dv0, dtag0); else passed++;
    tick();
    sd_valid = 0;
    #1;
    total++; if (dv0 !== 1'b0) $display("FAIL sd_clear got=%0d exp=0", dv0); else passed++;
    idle();
  endtask

  task automatic test_bypass();
    reset_dut();
    alu_pairs(6);
    drive(1, 0, 1, 5, 1, 1, 0, 5);
    #1;
    total++; if ({issue0, issue1, tag0, tag1} !== {2'b11, 5'd12, 5'd13}) $display("FAIL byp_tags got=%b,%0d,%0d exp=11,12,13", {issue0, issue1}, tag0, tag1); else passed++;
    total++; if ({dv1, dtag1} !== {1'b1, 5'd12}) $display("FAIL byp_dep got=%0d/%0d exp=1/12", dv1, dtag1); else passed++;
    tick();
    drive(1, 0, 1, 5, 1, 0, 1, 5);
    #1;
    total++; if ({dv0, dtag0} !== {1'b1, 5'd12}) $display("FAIL lfst5 got=%0d/%0d exp=1/12", dv0, dtag0); else passed++;
    total++; if ({dv1, dtag1} !== {1'b1, 5'd14}) $display("FAIL byp_st got=%0d/%0d exp=1/14", dv1, dtag1); else passed++;
    tick();
    drive(1, 0, 1, 5, 0, 0, 0, 0);
    sd_valid = 1; sd_tag = 15;
    #1;
    total++; if ({dv0, dtag0} !== {1'b1, 5'd15}) $display("FAIL wr1_wins got=%0d/%0d exp=1/15", dv0, dtag0); else passed++;
    tick();
    drive(1, 1, 0, 5, 0, 0, 0, 0);
    sd_valid = 0;
    #1;
    total++; if ({dv0, dtag0} !== {1'b1, 5'd16}) $display("FAIL wr_over_clr got=%0d/%0d exp=1/16", dv0, dtag0); else passed++;
    tick();
    idle();
  endtask

  task automatic test_wrap_lsq();
    reset_dut();
    alu_pairs(15);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    commit = 2;
    tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    commit = 0;
    #1;
    total++; if ({issue0, issue1, tag0, tag1} !== {2'b11, 5'd31, 5'd0}) $display("FAIL wrap_tags got=%b,%0d,%0d exp=11,31,0", {issue0, issue1}, tag0, tag1); else passed++;
    tick();
    idle();
    total++; if ({tag0, rob_free} !== {5'd1, 6'd1}) $display("FAIL wrap_tail got=%0d rob=%0d exp=1 rob=1", tag0, rob_free); else passed++;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 0, 1, 1, 0, 0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 1, 0, 1, 0);
    #1;
    total++; if (lsq_free !== 5'd1) $display("FAIL lsq_one got=%0d exp=1", lsq_free); else passed++;
    total++; if ({issue0, issue1, stall} !== 3'b101) $display("FAIL lsq_split got=%b exp=101", {issue0, issue1, stall}); else passed++;
    tick();
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    release_cnt = 1;
    #1;
    total++; if ({issue1, stall} !== 2'b01) $display("FAIL lsq_empty got=%b exp=01", {issue1, stall}); else passed++;
    tick();
    release_cnt = 0;
    #1;
    total++; if ({lsq_free, issue1} !== {5'd1, 1'b1}) $display("FAIL lsq_release got=%0d/%0d exp=1/1", lsq_free, issue1); else passed++;
    tick();
    idle();
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1, 0, 1, 2, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    flush = 1; sd_valid = 1; sd_tag = 9;
    #1;
    total++; if ({issue0, issue1} !== 2'b00) $display("FAIL flush_issue got=%b exp=00", {issue0, issue1}); else passed++;
    total++; if ({tag0, rob_free, lsq_free} !== {5'd1, 6'd31, 5'd15}) $display("FAIL pre_flush got=%0d/%0d/%0d exp=1/31/15", tag0, rob_free, lsq_free); else passed++;
    tick();
    idle();
    drive(1, 1, 0, 2, 0, 0, 0, 0);
    #1;
    total++; if ({tag0, rob_free, lsq_free} !== {5'd0, 6'd32, 5'd16}) $display("FAIL post_flush got=%0d/%0d/%0d exp=0/32/16", tag0, rob_free, lsq_free); else passed++;
    total++; if (dv0 !== 1'b0) $display("FAIL flush_lfst got=%0d exp=0", dv0); else passed++;
    tick();
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_two_alu();
    test_rob_limit();
    test_store_set();
    test_bypass();
    test_wrap_lsq();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
